flash_spi_engine: RTL and testbench



---
 rtl/flash_spi_engine.sv | 216 +++++++++++++++++++++
 tb/tb_flash_spi_engine.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_spi_engine.sv
`default_nettype none
// ============================================================================
//  Module      : flash_spi_engine
//  Description : Byte-wide SPI mode-0 shift engine with CS setup/hold
//                sequencing; CS may stay low across bytes of one transaction.
//  Revision    : 1.0 - initial release
// ============================================================================
module flash_spi_engine #(
   parameter int CLK_DIV  = 4,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] din,
   input  logic       keep_cs,
   output logic [7:0] dout,
   output logic       done,
   output logic       busy,
   output logic       spi_clk,
   output logic       spi_cs,
   output logic       spi_mosi,
   input  logic       spi_miso
);

   localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int WAIT_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
   localparam int WAIT_W   = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

   localparam logic [DIV_W-1:0]  c_div_last   = DIV_W'(CLK_DIV - 1);
   localparam logic [WAIT_W-1:0] c_setup_last = WAIT_W'(CS_SETUP - 1);
   localparam logic [WAIT_W-1:0] c_hold_last  = WAIT_W'(CS_HOLD - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      SHIFT = 3'd2,
      NEXT  = 3'd3,
      HOLD  = 3'd4,
      GAP   = 3'd5
   } state_t;

   state_t            state_q, state_d;
   logic [DIV_W-1:0]  div_q,   div_d;
   logic [WAIT_W-1:0] wait_q,  wait_d;
   logic [2:0]        bit_q,   bit_d;
   logic              lead_q,  lead_d;
   logic [6:0]        tx_q,    tx_d;
   logic [7:0]        rx_q,    rx_d;
   logic              keep_q,  keep_d;
   logic [7:0]        dout_q,  dout_d;
   logic              done_q,  done_d;
   logic              busy_q,  busy_d;
   logic              sck_q,   sck_d;
   logic              cs_q,    cs_d;
   logic              mosi_q,  mosi_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         div_q   <= '0;
         wait_q  <= '0;
         bit_q   <= '0;
         lead_q  <= 1'b0;
         tx_q    <= '0;
         rx_q    <= '0;
         keep_q  <= 1'b0;
         dout_q  <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         sck_q   <= 1'b0;
         cs_q    <= 1'b1;
         mosi_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         wait_q  <= wait_d;
         bit_q   <= bit_d;
         lead_q  <= lead_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         keep_q  <= keep_d;
         dout_q  <= dout_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         sck_q   <= sck_d;
         cs_q    <= cs_d;
         mosi_q  <= mosi_d;
      end
   end

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      wait_d  = wait_q;
      bit_d   = bit_q;
      lead_d  = lead_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      keep_d  = keep_q;
      dout_d  = dout_q;
      done_d  = 1'b0;
      busy_d  = busy_q;
      sck_d   = sck_q;
      cs_d    = cs_q;
      mosi_d  = mosi_q;

      unique case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            cs_d   = 1'b1;
            sck_d  = 1'b0;
            if (start) begin
               state_d = SETUP;
               wait_d  = '0;
               tx_d    = din[6:0];
               keep_d  = keep_cs;
               mosi_d  = din[7];
               cs_d    = 1'b0;
               busy_d  = 1'b1;
            end
         end

         SETUP: begin
            if (wait_q == c_setup_last) begin
               state_d = SHIFT;
               div_d   = '0;
               bit_d   = '0;
               lead_d  = 1'b1;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end

         SHIFT: begin
            // One lead cycle stretches the first low phase so MOSI has a
            // full extra clock of setup before the first rising edge.
            if (lead_q) begin
               lead_d = 1'b0;
            end else if (div_q != c_div_last) begin
               div_d = div_q + 1'b1;
            end else begin
               div_d = '0;
               sck_d = ~sck_q;
               if (!sck_q) begin
                  rx_d = {rx_q[6:0], spi_miso};
               end else if (bit_q == 3'd7) begin
                  dout_d = rx_q;
                  done_d = 1'b1;
                  if (keep_q) begin
                     state_d = NEXT;
                     busy_d  = 1'b0;
                  end else begin
                     state_d = HOLD;
                     wait_d  = '0;
                  end
               end else begin
                  bit_d  = bit_q + 3'd1;
                  mosi_d = tx_q[6];
                  tx_d   = {tx_q[5:0], 1'b0};
               end
            end
         end

         NEXT: begin
            busy_d = 1'b0;
            if (start) begin
               state_d = SHIFT;
               tx_d    = din[6:0];
               keep_d  = keep_cs;
               mosi_d  = din[7];
               busy_d  = 1'b1;
               div_d   = '0;
               bit_d   = '0;
               lead_d  = 1'b1;
            end
         end

         HOLD: begin
            if (wait_q == c_hold_last) begin
               state_d = GAP;
               cs_d    = 1'b1;
               wait_d  = '0;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end

         GAP: begin
            if (wait_q == c_hold_last) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            cs_d    = 1'b1;
            sck_d   = 1'b0;
         end
      endcase
   end

   assign dout     = dout_q;
   assign done     = done_q;
   assign busy     = busy_q;
   assign spi_clk  = sck_q;
   assign spi_cs   = cs_q;
   assign spi_mosi = mosi_q;

endmodule
`default_nettype wire

// File: tb/tb_flash_spi_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_flash_spi_engine
//  Description : Scoreboard bench for flash_spi_engine at default and minimum
//                timing parameters.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_flash_spi_engine;

   localparam int CLK_DIV_A  = 4;
   localparam int CS_SETUP_A = 2;
   localparam int CS_HOLD_A  = 2;
   localparam int CLK_DIV_B  = 1;
   localparam int CS_SETUP_B = 1;
   localparam int CS_HOLD_B  = 1;

   typedef struct {
      logic [7:0] rx;
      logic [7:0] tx;
      logic       keep;
      int         cyc;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic       reset;
   logic       start_a, keep_a, start_b, keep_b;
   logic [7:0] din_a, din_b;
   logic [7:0] dout_a, dout_b;
   logic       done_a, busy_a, spi_clk_a, spi_cs_a, spi_mosi_a, miso_a;
   logic       done_b, busy_b, spi_clk_b, spi_cs_b, spi_mosi_b, miso_b;

   // miso_mode: 0 tied low, 1 tied high, 2 loopback, 3 flash slave model
   int         miso_mode = 2;
   int         slave_rises = 0;
   logic [7:0] slave_pat = 8'h55;
   logic [2:0] slave_idx;
   logic       slave_bit;
   always_comb begin
      slave_idx = 3'(7 - (slave_rises % 8));
      slave_bit = ((slave_rises / 8) == 3) ? slave_pat[slave_idx] : 1'b0;
   end
   assign miso_a = (miso_mode == 2) ? spi_mosi_a :
                   (miso_mode == 1) ? 1'b1 :
                   (miso_mode == 3) ? slave_bit : 1'b0;
   assign miso_b = spi_mosi_b;

   flash_spi_engine #(.CLK_DIV(CLK_DIV_A), .CS_SETUP(CS_SETUP_A), .CS_HOLD(CS_HOLD_A)) u_dut_a (
      .clk(clk), .reset(reset), .start(start_a), .din(din_a), .keep_cs(keep_a),
      .dout(dout_a), .done(done_a), .busy(busy_a), .spi_clk(spi_clk_a),
      .spi_cs(spi_cs_a), .spi_mosi(spi_mosi_a), .spi_miso(miso_a));

   flash_spi_engine #(.CLK_DIV(CLK_DIV_B), .CS_SETUP(CS_SETUP_B), .CS_HOLD(CS_HOLD_B)) u_dut_b (
      .clk(clk), .reset(reset), .start(start_b), .din(din_b), .keep_cs(keep_b),
      .dout(dout_b), .done(done_b), .busy(busy_b), .spi_clk(spi_clk_b),
      .spi_cs(spi_cs_b), .spi_mosi(spi_mosi_b), .spi_miso(miso_b));

   int n_checks = 0;
   int n_fails  = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fails++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                  nm, act, act, exp, exp, cyc);
      end
   endtask

   exp_t qa[$];
   exp_t qb[$];
   logic prev_keep_a = 1'b0;
   logic prev_keep_b = 1'b0;

   // ---------------- monitor, default-parameter instance ----------------
   logic       prev_sck_a = 1'b0, prev_cs_a = 1'b1, prev_busy_a = 1'b0;
   logic       last_keep_a = 1'b0, first_rise_a = 1'b0;
   int         rise_byte_a = 0, cs_fall_cyc_a = 0, last_done_cyc_a = 0;
   logic [7:0] mosi_cap_a = 8'h00;

   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         rise_byte_a  = 0;
         slave_rises  = 0;
         first_rise_a = 1'b0;
      end else begin
         if (!spi_cs_a && prev_cs_a) begin
            cs_fall_cyc_a = cyc;
            first_rise_a  = 1'b1;
         end
         if (spi_cs_a && !prev_cs_a) begin
            chk("cs_rise_only_after_final_byte_a", int'(last_keep_a), 0);
            chk("cs_hold_a", cyc - last_done_cyc_a, CS_HOLD_A);
         end
         if (spi_clk_a && !prev_sck_a) begin
            if (first_rise_a) begin
               chk("cs_setup_a", int'((cyc - cs_fall_cyc_a) >= CS_SETUP_A), 1);
               first_rise_a = 1'b0;
            end
            mosi_cap_a = {mosi_cap_a[6:0], spi_mosi_a};
            rise_byte_a++;
            slave_rises++;
         end
         if (spi_cs_a) slave_rises = 0;
         if (!busy_a && prev_busy_a) begin
            if (spi_cs_a) chk("cs_gap_a", cyc - last_done_cyc_a, 2 * CS_HOLD_A);
            else          chk("busy_drop_with_done_a", int'(done_a), 1);
         end
         if (done_a) begin
            if (qa.size() == 0) begin
               chk("unexpected_done_a", int'(done_a), 0);
            end else begin
               e = qa.pop_front();
               chk("dout_a", int'(dout_a), int'(e.rx));
               chk("done_cycle_a", cyc, e.cyc);
               chk("mosi_bits_a", int'(mosi_cap_a), int'(e.tx));
               chk("sck_rises_a", rise_byte_a, 8);
               chk("busy_at_done_a", int'(busy_a), e.keep ? 0 : 1);
               last_keep_a = e.keep;
            end
            last_done_cyc_a = cyc;
            rise_byte_a     = 0;
         end
      end
      prev_sck_a  = spi_clk_a;
      prev_cs_a   = spi_cs_a;
      prev_busy_a = busy_a;
   end

   // ---------------- monitor, minimum-parameter instance ----------------
   logic prev_sck_b = 1'b0;
   int   rise_b = 0, last_rise_b = 0;

   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         rise_b = 0;
      end else begin
         if (spi_clk_b && !prev_sck_b) begin
            if (rise_b > 0) chk("sck_period_b", cyc - last_rise_b, 2 * CLK_DIV_B);
            last_rise_b = cyc;
            rise_b++;
         end
         if (done_b) begin
            if (qb.size() == 0) begin
               chk("unexpected_done_b", int'(done_b), 0);
            end else begin
               e = qb.pop_front();
               chk("dout_b", int'(dout_b), int'(e.rx));
               chk("done_cycle_b", cyc, e.cyc);
               chk("sck_rises_b", rise_b, 8);
            end
            rise_b = 0;
         end
      end
      prev_sck_b = spi_clk_b;
   end

   // ---------------- stimulus ----------------
   // Called on a falling edge; optionally holds start high until done.
   task automatic send_a(input logic [7:0] d, input logic k, input logic [7:0] rx,
                         input logic hold);
      exp_t e;
      int   n = 0;
      while (busy_a && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (busy_a) begin
         chk("busy_timeout_a", int'(busy_a), 0);
         return;
      end
      e.rx   = rx;
      e.tx   = d;
      e.keep = k;
      e.cyc  = cyc + 2 + (prev_keep_a ? 0 : CS_SETUP_A) + 16 * CLK_DIV_A;
      qa.push_back(e);
      din_a   = d;
      keep_a  = k;
      start_a = 1'b1;
      prev_keep_a = k;
      if (hold) begin
         n = 0;
         do begin
            @(negedge clk);
            din_a = 8'($urandom);
            n++;
         end while (!done_a && n < 400);
      end else begin
         @(negedge clk);
      end
      start_a = 1'b0;
   endtask

   task automatic send_b(input logic [7:0] d, input logic k);
      exp_t e;
      int   n = 0;
      while (busy_b && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (busy_b) begin
         chk("busy_timeout_b", int'(busy_b), 0);
         return;
      end
      e.rx   = d;
      e.tx   = d;
      e.keep = k;
      e.cyc  = cyc + 2 + (prev_keep_b ? 0 : CS_SETUP_B) + 16 * CLK_DIV_B;
      qb.push_back(e);
      din_b   = d;
      keep_b  = k;
      start_b = 1'b1;
      prev_keep_b = k;
      @(negedge clk);
      start_b = 1'b0;
   endtask

   task automatic drain_a();
      int n = 0;
      while (qa.size() != 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (qa.size() != 0) begin
         chk("drain_timeout_a", qa.size(), 0);
         qa.delete();
      end
   endtask

   task automatic drain_b();
      int n = 0;
      while (qb.size() != 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (qb.size() != 0) begin
         chk("drain_timeout_b", qb.size(), 0);
         qb.delete();
      end
   endtask

   task automatic check_reset_a();
      chk("rst_cs_a",   int'(spi_cs_a),   1);
      chk("rst_sck_a",  int'(spi_clk_a),  0);
      chk("rst_mosi_a", int'(spi_mosi_a), 0);
      chk("rst_busy_a", int'(busy_a),     0);
      chk("rst_done_a", int'(done_a),     0);
      chk("rst_dout_a", int'(dout_a),     0);
   endtask

   initial begin
      int n;
      reset   = 1'b1;
      start_a = 1'b0; din_a = 8'h00; keep_a = 1'b0;
      start_b = 1'b0; din_b = 8'h00; keep_b = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_a();
      reset = 1'b0;
      @(negedge clk);

      miso_mode = 2;
      send_a(8'hA5, 1'b0, 8'hA5, 1'b0);
      drain_a();
      miso_mode = 1;
      send_a(8'h00, 1'b0, 8'hFF, 1'b0);
      drain_a();
      miso_mode = 0;
      send_a(8'hC3, 1'b0, 8'h00, 1'b0);
      drain_a();

      // flash read: command, address, dummy, then data from the slave
      miso_mode = 3;
      send_a(8'h03, 1'b1, 8'h00, 1'b0);
      drain_a();
      send_a(8'h01, 1'b1, 8'h00, 1'b0);
      drain_a();
      send_a(8'hAA, 1'b1, 8'h00, 1'b0);
      drain_a();
      send_a(8'h00, 1'b0, 8'h55, 1'b0);
      drain_a();

      miso_mode = 2;
      send_a(8'h3C, 1'b0, 8'h3C, 1'b1);
      drain_a();

      // start issued on the cycle right after done while in NEXT
      send_a(8'h81, 1'b1, 8'h81, 1'b0);
      n = 0;
      while (!done_a && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (!done_a) chk("done_timeout_a", int'(done_a), 1);
      send_a(8'h7E, 1'b0, 8'h7E, 1'b0);
      drain_a();

      // reset in the middle of a byte
      send_a(8'h5A, 1'b0, 8'h5A, 1'b0);
      repeat (20) @(negedge clk);
      reset = 1'b1;
      qa.delete();
      prev_keep_a = 1'b0;
      prev_keep_b = 1'b0;
      @(negedge clk);
      check_reset_a();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (120) @(negedge clk);

      send_b(8'h3C, 1'b0);
      drain_b();
      send_b(8'hC5, 1'b1);
      drain_b();
      send_b(8'h0F, 1'b0);
      drain_b();

      n = 0;
      while ((busy_a || busy_b) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("final_idle_a", int'(busy_a), 0);
      chk("final_idle_b", int'(busy_b), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
`default_nettype wire
